// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: channel widths, AXIS byte lanes, pixel type, frame length.
// Used by both the column-scanning input buffer and output_buffer.
package img_pkg;

   localparam int unsigned IMG_DATA_WIDTH = 8;
   localparam int unsigned IMG_BLOCK_SIZE = 3;
   localparam int unsigned AXIS_WIDTH     = 32;

   localparam int unsigned LANE_R_MSB = 31;
   localparam int unsigned LANE_R_LSB = 24;
   localparam int unsigned LANE_G_MSB = 23;
   localparam int unsigned LANE_G_LSB = 16;
   localparam int unsigned LANE_B_MSB = 15;
   localparam int unsigned LANE_B_LSB = 8;

   typedef struct packed {
      logic [IMG_DATA_WIDTH-1:0] r;
      logic [IMG_DATA_WIDTH-1:0] g;
      logic [IMG_DATA_WIDTH-1:0] b;
   } pixel_t;

   typedef enum logic {
      FR_IDLE  = 1'b0,
      FR_ARMED = 1'b1
   } frame_state_e;

   // Beats per column frame: kernel apron plus the valid rows.
   function automatic int unsigned frame_len(input int unsigned block_size,
                                             input int unsigned input_height);
      return block_size - 1 + input_height;
   endfunction

   function automatic logic [AXIS_WIDTH-1:0] pack_pixel(input pixel_t pix);
      logic [AXIS_WIDTH-1:0] word;
      word = '0;
      word[LANE_R_MSB:LANE_R_LSB] = pix.r;
      word[LANE_G_MSB:LANE_G_LSB] = pix.g;
      word[LANE_B_MSB:LANE_B_LSB] = pix.b;
      return word;
   endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register: loads when empty or draining, holds under back pressure.
// Optional start-of-image sideband when OUTPUT_BUFFER_SOF_TUSER_EN is defined.
module axis_out_reg
   import img_pkg::*;
#(
   parameter int unsigned DATA_W = AXIS_WIDTH
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_last,
`ifdef OUTPUT_BUFFER_SOF_TUSER_EN
   input  logic              i_user,
   output logic              o_user,
`endif
   input  logic              i_ready,
   output logic              o_can_load_c,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic              o_last
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic              r_last;
`ifdef OUTPUT_BUFFER_SOF_TUSER_EN
   logic              r_user;
`endif

   // Slot is free when empty or when its current beat is being accepted this cycle.
   assign o_can_load_c = !r_valid || i_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_last  <= 1'b0;
`ifdef OUTPUT_BUFFER_SOF_TUSER_EN
         r_user  <= 1'b0;
`endif
      end else if (o_can_load_c) begin
         if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
`ifdef OUTPUT_BUFFER_SOF_TUSER_EN
            r_user  <= i_user;
`endif
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_last  = r_last;
`ifdef OUTPUT_BUFFER_SOF_TUSER_EN
   assign o_user  = r_user;
`endif

endmodule

// File: rtl/output_buffer.sv
// Column-frame pixel extractor and AXI-Stream master for the 3-channel processing block.
// Define OUTPUT_BUFFER_SOF_TUSER_EN to add the start-of-image m_tuser sideband.
module output_buffer
   import img_pkg::*;
#(
   parameter int unsigned DATA_WIDTH         = IMG_DATA_WIDTH,
   parameter int unsigned BLOCK_SIZE         = IMG_BLOCK_SIZE,
   parameter int unsigned INPUT_HEIGHT       = 480,
   parameter int unsigned OUTPUT_WIDTH       = 640,
   parameter int unsigned ROW_OFFSET         = BLOCK_SIZE / 2,
   parameter int unsigned C_AXIS_TDATA_WIDTH = AXIS_WIDTH
) (
   input  logic                            aclk,
   input  logic                            areset,
   input  logic [DATA_WIDTH-1:0]           result_R,
   input  logic [DATA_WIDTH-1:0]           result_G,
   input  logic [DATA_WIDTH-1:0]           result_B,
   input  logic                            data_flowing,
   input  logic                            is_full_columns_first_input,
   output logic                            output_has_back_pressure,
   output logic                            output_buffer_is_done,
   output logic                            m_tvalid,
   input  logic                            m_tready,
   output logic [C_AXIS_TDATA_WIDTH-1:0]   m_tdata,
   output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_tstrb,
`ifdef OUTPUT_BUFFER_SOF_TUSER_EN
   output logic                            m_tuser,
`endif
   output logic                            m_tlast
);

   localparam int unsigned FRAME_LEN = frame_len(BLOCK_SIZE, INPUT_HEIGHT);
   localparam int unsigned BEAT_W    = $clog2(FRAME_LEN + 1);
   localparam int unsigned ROW_W     = $clog2(INPUT_HEIGHT + 1);
   localparam int unsigned COL_W     = $clog2(OUTPUT_WIDTH + 1);
   localparam int unsigned CAP_LO    = ROW_OFFSET;
   localparam int unsigned CAP_HI    = ROW_OFFSET + INPUT_HEIGHT;

   frame_state_e           r_frame_st;
   logic [BEAT_W-1:0]      r_beat_cnt;
   logic [ROW_W-1:0]       r_row_cnt;
   logic [COL_W-1:0]       r_col_cnt;
   logic                   r_done;

   logic                   w_beat_live;
   logic [BEAT_W-1:0]      w_beat_idx;
   logic                   w_capture;
   logic                   w_can_load;
   logic                   w_load;
   logic                   w_handshake;
   logic                   w_row_last;
   logic                   w_col_last;
   logic [ROW_W-1:0]       w_row_nxt;
   logic [COL_W-1:0]       w_col_nxt;
   logic                   w_pix_last;
   pixel_t                 w_pix;
   logic [C_AXIS_TDATA_WIDTH-1:0] w_word;

   // r_beat_cnt holds the index the next armed beat will carry; a flagged beat is always index 0.
   assign w_beat_live = data_flowing && (is_full_columns_first_input || (r_frame_st == FR_ARMED));
   assign w_beat_idx  = is_full_columns_first_input ? '0 : r_beat_cnt;
   assign w_capture   = w_beat_live
                        && (w_beat_idx >= BEAT_W'(CAP_LO))
                        && (w_beat_idx <  BEAT_W'(CAP_HI));

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_frame_st <= FR_IDLE;
         r_beat_cnt <= '0;
      end else if (w_beat_live) begin
         if (w_beat_idx == BEAT_W'(FRAME_LEN - 1)) begin
            r_frame_st <= FR_IDLE;
            r_beat_cnt <= '0;
         end else begin
            r_frame_st <= FR_ARMED;
            r_beat_cnt <= w_beat_idx + BEAT_W'(1);
         end
      end
   end

   assign w_handshake = m_tvalid && m_tready;
   assign w_row_last  = (r_row_cnt == ROW_W'(INPUT_HEIGHT - 1));
   assign w_col_last  = (r_col_cnt == COL_W'(OUTPUT_WIDTH - 1));

   // Position counters after this cycle's handshake, i.e. the slot a pixel loaded now will occupy.
   always_comb begin
      w_row_nxt = r_row_cnt;
      w_col_nxt = r_col_cnt;
      if (w_handshake) begin
         if (w_row_last) begin
            w_row_nxt = '0;
            w_col_nxt = w_col_last ? '0 : r_col_cnt + COL_W'(1);
         end else begin
            w_row_nxt = r_row_cnt + ROW_W'(1);
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_row_cnt <= '0;
         r_col_cnt <= '0;
         r_done    <= 1'b0;
      end else begin
         r_row_cnt <= w_row_nxt;
         r_col_cnt <= w_col_nxt;
         r_done    <= w_handshake && w_row_last;
      end
   end

   assign w_pix      = '{r: IMG_DATA_WIDTH'(result_R),
                         g: IMG_DATA_WIDTH'(result_G),
                         b: IMG_DATA_WIDTH'(result_B)};
   assign w_word     = C_AXIS_TDATA_WIDTH'(pack_pixel(w_pix));
   assign w_pix_last = (w_row_nxt == ROW_W'(INPUT_HEIGHT - 1))
                       && (w_col_nxt == COL_W'(OUTPUT_WIDTH - 1));
   // A capture arriving while the slot is blocked is a protocol violation and is dropped.
   assign w_load     = w_capture && w_can_load;

`ifdef OUTPUT_BUFFER_SOF_TUSER_EN
   logic w_pix_sof;
   assign w_pix_sof = (w_row_nxt == '0) && (w_col_nxt == '0);
`endif

   axis_out_reg #(
      .DATA_W (C_AXIS_TDATA_WIDTH)
   ) u_out_reg (
      .i_clk        (aclk),
      .i_rst        (areset),
      .i_load       (w_load),
      .i_data       (w_word),
      .i_last       (w_pix_last),
`ifdef OUTPUT_BUFFER_SOF_TUSER_EN
      .i_user       (w_pix_sof),
      .o_user       (m_tuser),
`endif
      .i_ready      (m_tready),
      .o_can_load_c (w_can_load),
      .o_valid      (m_tvalid),
      .o_data       (m_tdata),
      .o_last       (m_tlast)
   );

   assign output_has_back_pressure = m_tvalid && !m_tready;
   assign output_buffer_is_done    = r_done;
   assign m_tstrb                  = '1;

endmodule

// File: tb/tb_output_buffer.sv
// Randomized self-checking bench for output_buffer against a queue-based pixel model.
// Covers m_tuser when OUTPUT_BUFFER_SOF_TUSER_EN is defined.
module tb_output_buffer;

   localparam int BS = 3;
   localparam int H  = 4;
   localparam int W  = 2;
   localparam int RO = 1;
   localparam int FL = BS - 1 + H;
`ifdef OUTPUT_BUFFER_SOF_TUSER_EN
   localparam bit SOF_EN = 1'b1;
`else
   localparam bit SOF_EN = 1'b0;
`endif

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic [7:0]  result_R = '0, result_G = '0, result_B = '0;
   logic        data_flowing = 1'b0;
   logic        is_first = 1'b0;
   logic        bp, done, m_tvalid, m_tlast;
   logic        m_tready = 1'b0;
   logic [31:0] m_tdata;
   logic [3:0]  m_tstrb;
   logic        user_obs;
`ifdef OUTPUT_BUFFER_SOF_TUSER_EN
   logic        m_tuser;
   assign user_obs = m_tuser;
`else
   assign user_obs = 1'b0;
`endif

   output_buffer #(
      .DATA_WIDTH(8), .BLOCK_SIZE(BS), .INPUT_HEIGHT(H), .OUTPUT_WIDTH(W),
      .ROW_OFFSET(RO), .C_AXIS_TDATA_WIDTH(32)
   ) dut (
      .aclk(aclk), .areset(areset),
      .result_R(result_R), .result_G(result_G), .result_B(result_B),
      .data_flowing(data_flowing), .is_full_columns_first_input(is_first),
      .output_has_back_pressure(bp), .output_buffer_is_done(done),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tstrb(m_tstrb),
`ifdef OUTPUT_BUFFER_SOF_TUSER_EN
      .m_tuser(m_tuser),
`endif
      .m_tlast(m_tlast)
   );

   always #5 aclk = ~aclk;

   int errors = 0;
   int checks = 0;

   // Model: {last, user, data} per expected pixel, plus expected done pulses.
   logic [33:0] exp_q[$];
   logic [33:0] obs_q[$];
   int unsigned mdl_n = 0;
   int exp_done = 0;

   int cyc = 0, hs_cyc = 0, done_cyc = 0, done_cnt = 0, viol = 0;

   // Records accepted beats and done pulses.
   always @(negedge aclk) begin
      cyc++;
      if (m_tvalid && m_tready) begin
         obs_q.push_back({m_tlast, user_obs, m_tdata});
         hs_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (data_flowing && bp) viol++;
   end

   task automatic push_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      logic [33:0] e;
      int unsigned p;
      p = mdl_n % (H * W);
      e[31:0] = {r, g, b, 8'h00};
      e[33]   = (p == H * W - 1);
      e[32]   = SOF_EN && (p == 0);
      exp_q.push_back(e);
      if (mdl_n % H == H - 1) exp_done++;
      mdl_n++;
   endtask

   // One processing-block beat; a compliant upstream never flows while stalled.
   task automatic beat(input logic first, input int idx, input logic idx_red, input logic stall);
      logic [7:0] r, g, b;
      int guard;
      guard = 0;
      r = idx_red ? 8'(idx) : 8'($urandom);
      g = 8'($urandom);
      b = 8'($urandom);
      forever begin
         @(posedge aclk); #1;
         m_tready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
         if ((m_tvalid && !m_tready) || (stall && $urandom_range(0, 4) == 0)) begin
            data_flowing = 1'b0;
            is_first     = 1'b0;
            guard++;
            if (guard > 200) begin
               checks++; errors++;
               $display("FAIL beat_stall_timeout got stuck want progress");
               break;
            end
         end else begin
            data_flowing = 1'b1;
            is_first     = first;
            result_R = r; result_G = g; result_B = b;
            break;
         end
      end
      if (idx >= RO && idx < RO + H) push_pixel(r, g, b);
   endtask

   task automatic frame(input logic idx_red, input logic stall);
      beat(1'b1, 0, idx_red, stall);
      for (int i = 1; i < FL; i++) beat(1'b0, i, idx_red, stall);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge aclk); #1;
         data_flowing = 1'b0;
         is_first     = 1'b0;
         m_tready     = 1'b1;
      end
   endtask

   task automatic do_reset();
      @(posedge aclk); #1;
      areset = 1'b1; data_flowing = 1'b0; is_first = 1'b0; m_tready = 1'b0;
      @(posedge aclk); #1;
      areset = 1'b0; m_tready = 1'b1;
      exp_q.delete(); obs_q.delete();
      mdl_n = 0; exp_done = 0; done_cnt = 0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b want 0", m_tvalid); end
      checks++; if (m_tdata !== 32'h0) begin errors++; $display("FAIL rst_tdata got %h want 0", m_tdata); end
      checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b want 0", m_tlast); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
      checks++; if (bp !== 1'b0) begin errors++; $display("FAIL rst_bp got %b want 0", bp); end
      checks++; if (m_tstrb !== 4'hF) begin errors++; $display("FAIL rst_tstrb got %h want f", m_tstrb); end
      checks++; if (user_obs !== 1'b0) begin errors++; $display("FAIL rst_tuser got %b want 0", user_obs); end
      do_reset();
   endtask

   task automatic test_basic_column();
      do_reset();
      beat(1'b1, 0, 1'b1, 1'b0);
      beat(1'b0, 1, 1'b1, 1'b0);
      @(negedge aclk);
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL basic_latency_early got %b want 0", m_tvalid); end
      beat(1'b0, 2, 1'b1, 1'b0);
      @(negedge aclk);
      checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL basic_latency got %b want 1", m_tvalid); end
      checks++; if (m_tdata !== exp_q[0][31:0]) begin errors++; $display("FAIL basic_first_data got %h want %h", m_tdata, exp_q[0][31:0]); end
      for (int i = 3; i < FL; i++) beat(1'b0, i, 1'b1, 1'b0);
      idle(6);
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_pixel%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      checks++; if (done_cnt !== exp_done) begin errors++; $display("FAIL basic_done_count got %0d want %0d", done_cnt, exp_done); end
      checks++; if (done_cyc !== hs_cyc + 1) begin errors++; $display("FAIL basic_done_timing got %0d want %0d", done_cyc, hs_cyc + 1); end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_image_end();
      do_reset();
      frame(1'b0, 1'b0);
      frame(1'b0, 1'b0);
      idle(6);
      checks++; if (obs_q.size() !== 8) begin errors++; $display("FAIL img_count got %0d want 8", obs_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL img_pixel%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      obs_q.delete(); exp_q.delete();
      frame(1'b0, 1'b0);
      idle(6);
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL img_next_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL img_next_pixel%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      checks++; if (done_cnt !== exp_done) begin errors++; $display("FAIL img_done_count got %0d want %0d", done_cnt, exp_done); end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_back_pressure();
      do_reset();
      beat(1'b1, 0, 1'b0, 1'b0);
      beat(1'b0, 1, 1'b0, 1'b0);
      @(negedge aclk);
      checks++; if (bp !== 1'b0) begin errors++; $display("FAIL bp_before got %b want 0", bp); end
      for (int k = 0; k < 3; k++) begin
         @(posedge aclk); #1;
         data_flowing = 1'b0; is_first = 1'b0; m_tready = 1'b0;
         @(negedge aclk);
         checks++; if (bp !== 1'b1) begin errors++; $display("FAIL bp_cycle%0d got %b want 1", k, bp); end
         checks++; if (m_tdata !== exp_q[0][31:0]) begin errors++; $display("FAIL bp_hold%0d got %h want %h", k, m_tdata, exp_q[0][31:0]); end
      end
      for (int i = 2; i < FL; i++) beat(1'b0, i, 1'b0, 1'b0);
      idle(6);
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_pixel%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_unarmed();
      for (int i = 0; i < 10; i++) begin
         @(posedge aclk); #1;
         data_flowing = 1'b1; is_first = 1'b0; m_tready = 1'b1;
         result_R = 8'($urandom); result_G = 8'($urandom); result_B = 8'($urandom);
         @(negedge aclk);
         checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL unarmed_beat%0d got %b want 0", i, m_tvalid); end
      end
      idle(2);
      checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL unarmed_count got %0d want 0", obs_q.size()); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int i = 0; i < 4; i++) beat(i == 0, i, 1'b0, 1'b0);
      @(posedge aclk); #1;
      areset = 1'b1; data_flowing = 1'b0; is_first = 1'b0; m_tready = 1'b0;
      @(negedge aclk);
      checks++; if (obs_q.size() !== 2) begin errors++; $display("FAIL mid_pre_count got %0d want 2", obs_q.size()); end
      for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_pre_pixel%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      @(posedge aclk); #1;
      areset = 1'b0; m_tready = 1'b1;
      @(negedge aclk);
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid got %b want 0", m_tvalid); end
      checks++; if (m_tdata !== 32'h0) begin errors++; $display("FAIL mid_tdata got %h want 0", m_tdata); end
      checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL mid_tlast got %b want 0", m_tlast); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done got %b want 0", done); end
      exp_q.delete(); obs_q.delete();
      mdl_n = 0; exp_done = 0; done_cnt = 0;
      frame(1'b0, 1'b1);
      frame(1'b0, 1'b1);
      idle(8);
      checks++; if (obs_q.size() !== 8) begin errors++; $display("FAIL mid_post_count got %0d want 8", obs_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_post_pixel%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      checks++; if (done_cnt !== exp_done) begin errors++; $display("FAIL mid_done_count got %0d want %0d", done_cnt, exp_done); end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_random_stream();
      do_reset();
      for (int it = 0; it < 14; it++) begin
         int sel;
         sel = $urandom_range(0, 3);
         if (sel == 0) begin
            // Aborted frame: the next flagged beat restarts framing.
            for (int i = 0; i < 3; i++) beat(i == 0, i, 1'b0, 1'b1);
         end
         frame(1'b0, 1'b1);
         if (sel == 1) for (int i = 0; i < 3; i++) beat(1'b0, FL + i, 1'b0, 1'b1);
      end
      idle(10);
      checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_pixel%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      checks++; if (done_cnt !== exp_done) begin errors++; $display("FAIL rand_done_count got %0d want %0d", done_cnt, exp_done); end
      checks++; if (viol !== 0) begin errors++; $display("FAIL flow_under_backpressure got %0d want 0", viol); end
      obs_q.delete(); exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_basic_column();
      test_image_end();
      test_back_pressure();
      test_unarmed();
      test_mid_reset();
      test_random_stream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/output_buffer.md
# output_buffer

Collects per-row results from the 3-channel processing block and emits them as a 32-bit AXI-Stream master. It is the downstream partner of the column-scanning input buffer. It decides which processing-block beats carry valid pixels, drives the back-pressure and column-done signals consumed upstream, and marks the final pixel of an image with `m_tlast`.

## Interface
- `DATA_WIDTH`, 8: bits per colour channel.
- `BLOCK_SIZE`, 3: kernel width/height; column frame length `FRAME_LEN = INPUT_HEIGHT + BLOCK_SIZE - 1` beats.
- `INPUT_HEIGHT`, 480: valid output pixels per column.
- `OUTPUT_WIDTH`, 640: columns per image; `m_tlast` is driven on the last pixel of column `OUTPUT_WIDTH-1`.
- `ROW_OFFSET`, `BLOCK_SIZE/2`: beats skipped after frame start before the first valid pixel.
- `C_AXIS_TDATA_WIDTH`, 32: stream width. Fixed at 32.
- `aclk` in 1: sole clock. All logic is on the rising edge.
- `areset` in 1: synchronous, active-high reset.
- `result_R`, `result_G`, `result_B` in `DATA_WIDTH` each: processing-block output for the current beat.
- `data_flowing` in 1: the current cycle is a processing-block beat.
- `is_full_columns_first_input` in 1: when high on a beat, that beat is beat 0 of an armed column frame.
- `output_has_back_pressure` out 1: `m_tvalid && !m_tready`. Purely combinational.
- `output_buffer_is_done` out 1: one-cycle pulse when a column's last pixel is accepted.
- `m_tvalid` out 1, `m_tready` in 1, `m_tdata` out 32, `m_tstrb` out 4, `m_tlast` out 1: AXI-Stream master.

## Operation
- **State:** `armed` flag, `beat_cnt` (0..FRAME_LEN-1), `row_cnt` (0..INPUT_HEIGHT-1), `col_cnt` (0..OUTPUT_WIDTH-1), one output register.
- **Frame start:** a beat with `is_full_columns_first_input=1` sets `armed=1` and loads `beat_cnt=0`. This overrides any frame in progress.
- **Beat counting:** each later beat while armed increments `beat_cnt`. The beat with `beat_cnt==FRAME_LEN-1` clears `armed`.
- **Unarmed beats** are discarded.
- **Capture beat:** armed, `ROW_OFFSET <= beat_cnt < ROW_OFFSET+INPUT_HEIGHT`. On this beat:
  - `m_tdata <= {result_R, result_G, result_B, 8'h00}`, i.e. R in [31:24], G in [23:16], B in [15:8].
  - `m_tvalid <= 1`.
  - `m_tlast <= (row_cnt==INPUT_HEIGHT-1 && col_cnt==OUTPUT_WIDTH-1)`.
- **Output register:**
  - Holds its contents while `m_tvalid && !m_tready`.
  - Clears `m_tvalid` on handshake when no capture occurs in the same cycle.
  - Handshake and capture in the same cycle: the new pixel is loaded and `m_tvalid` stays 1.
- **Handshake accounting:** each handshake increments `row_cnt`.
  - At `row_cnt==INPUT_HEIGHT-1`: `row_cnt` wraps to 0, `col_cnt` increments, and `output_buffer_is_done` pulses on the next cycle.
  - At `col_cnt==OUTPUT_WIDTH-1`: `col_cnt` wraps to 0 (next image).
- **Capture during back pressure** (protocol violation; upstream must not flow): the beat is dropped and counters do not advance. The bench asserts this never occurs.
- `m_tstrb` is constant 4'hF.

## Timing
- **Reset values:**
  - `m_tvalid=0`, `m_tdata=0`, `m_tlast=0`, `output_buffer_is_done=0`, `output_has_back_pressure=0`.
  - `armed=0`; `beat_cnt`, `row_cnt`, `col_cnt` all 0.
  - Reset asserted mid-column discards the pending pixel and all progress.
- **Latency:** capture beat in cycle N gives `m_tvalid=1` in N+1.
- **Throughput:** one pixel per cycle sustained while `m_tready=1`.
- **Done pulse:** the last-pixel handshake in cycle N gives `output_buffer_is_done=1` in N+1 only.
- `m_tdata`, `m_tlast` and `m_tuser` are stable while `m_tvalid && !m_tready`.

## Configuration
- `OUTPUT_BUFFER_SOF_TUSER_EN` defined: adds output port `m_tuser` (1 bit, reset 0). It is 1 with the pixel at `row_cnt==0 && col_cnt==0` (start of image) and held with that pixel.
- Undefined: no `m_tuser` port. The start-of-image logic is absent.

## Structure
- Shared package `img_pkg` holds:
  - `DATA_WIDTH` and `BLOCK_SIZE` defaults, and the R/G/B byte-lane positions (31:24, 23:16, 15:8), shared with the input buffer;
  - the frame-length function `BLOCK_SIZE-1+INPUT_HEIGHT`;
  - a `pixel_t` struct {r, g, b}.
- Counter widths use `$clog2(n+1)`.
- One sub-module, `axis_out_reg`: the single-entry output register with valid/ready, load and hold logic. The frame, row and column counters stay in the top level.

## Test plan
All scenarios use `BLOCK_SIZE=3`, `INPUT_HEIGHT=4`, `OUTPUT_WIDTH=2`, `ROW_OFFSET=1` (FRAME_LEN=6).
- **Basic column:** flagged beat 0 then 5 beats with R=beat index, `m_tready=1` → 4 pixels, `m_tdata` = 0x01xxxx00..0x04xxxx00, `m_tlast=0`, `output_buffer_is_done` pulses once.
- **Image end:** two flagged frames → 8 pixels, `m_tlast=1` only on pixel 8; the next image restarts at `col_cnt=0`.
- **Back pressure:** `m_tready=0` for 3 cycles after the first capture → `output_has_back_pressure=1` for those 3 cycles, `m_tdata` held, no pixel lost or duplicated.
- **Unarmed traffic:** 10 beats without the flag → `m_tvalid` stays 0.
- **Mid-stream reset:** `areset` pulsed after pixel 2 → all outputs return to reset values; the next flagged frame emits 4 pixels starting at `row_cnt=0`.
- **Macro on:** `m_tuser=1` on the first pixel of each image only.
